// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter.
//   producer_e     : result producer index (ALU, branch, load/store, mul/div)
//   CDB_COUNT      : default number of common data bus slots per cycle
//   NUM_PRODUCERS  : default number of result producers
package pkg_defines;

  typedef enum logic [1:0] {
    ALU        = 2'd0,
    BRANCH     = 2'd1,
    LOAD_STORE = 2'd2,
    MUL_DIV    = 2'd3
  } producer_e;

  localparam int unsigned CDB_COUNT     = 2;
  localparam int unsigned NUM_PRODUCERS = 4;

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Wrap-around priority search: returns the first set bit of i_mask at or
// after i_start, wrapping from N-1 back to 0.
//   i_start : highest-priority index
//   i_mask  : candidate bit vector
//   o_valid : at least one candidate found
//   o_index : winning index (0 when o_valid is low)
module rr_select
  import pkg_defines::*;
#(
  parameter int unsigned N = NUM_PRODUCERS,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [W-1:0] i_start,
  input  logic [N-1:0] i_mask,
  output logic         o_valid,
  output logic [W-1:0] o_index
);

  logic [W-1:0] w_idx;

  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      w_idx = W'((32'(i_start) + off) % N);
      if (!o_valid && i_mask[w_idx]) begin
        o_valid = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to NUM_BUS result producers per cycle
// using rotating priority, with registered one-cycle grant pulses.
//   i_clock     : clock, all state on rising edge
//   i_reset     : synchronous active-high reset (wins over i_flush)
//   i_flush     : pipeline flush; clears grants/ages, keeps rotation pointer
//   i_request   : per-producer result-ready level
//   o_grant     : per-producer grant pulse
//   o_grant_bus : bus index per granted producer (0 when not granted)
//   o_bus_busy  : per-bus slot occupancy
// Build option: define CDB_ARBITER_AGING_EN to add per-producer age counters;
// producers waiting AGE_LIMIT cycles are served first, lowest index first.
module cdb_arbiter
  import pkg_defines::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_BUS   = CDB_COUNT,
  parameter int unsigned AGE_LIMIT = 8
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_flush,
  input  logic [NUM_REQ-1:0]                  i_request,
  output logic [NUM_REQ-1:0]                  o_grant,
  output logic [NUM_REQ*$clog2(NUM_BUS)-1:0]  o_grant_bus,
  output logic [NUM_BUS-1:0]                  o_bus_busy
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BUS_W  = $clog2(NUM_BUS);
  localparam int unsigned GBUS_W = NUM_REQ * BUS_W;

  if (NUM_BUS < 2 || AGE_LIMIT < 1) begin : g_param_check
    $error("cdb_arbiter: NUM_BUS must be >= 2 and AGE_LIMIT >= 1");
  end

  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_BUS-1:0] r_bus_busy;
  logic [GBUS_W-1:0]  r_grant_bus;
  logic [PTR_W-1:0]   r_rr_ptr;

  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_BUS-1:0] w_valid;
  logic [PTR_W-1:0]   w_index [NUM_BUS];
  // Per-bus accumulation chains: producers already taken, bus-index fields,
  // and the pointer following the most recent winner.
  logic [NUM_REQ-1:0] w_taken [NUM_BUS+1];
  logic [GBUS_W-1:0]  w_gbus  [NUM_BUS+1];
  logic [PTR_W-1:0]   w_ptr   [NUM_BUS+1];

  // A producer granted last cycle is still dropping its request.
  assign w_eligible = i_request & ~r_grant;

  assign w_taken[0] = '0;
  assign w_gbus[0]  = '0;
  assign w_ptr[0]   = r_rr_ptr;

`ifdef CDB_ARBITER_AGING_EN
  localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);
  logic [NUM_REQ-1:0] w_aged;
`endif

  for (genvar b = 0; b < NUM_BUS; b++) begin : g_bus
    logic [NUM_REQ-1:0] w_mask;
    logic [PTR_W-1:0]   w_start;
`ifdef CDB_ARBITER_AGING_EN
    // Aged producers are drained first in ascending order (search from 0);
    // only when none remain does this slot fall back to rotating priority.
    logic [NUM_REQ-1:0] w_aged_left;
    assign w_aged_left = w_aged & w_eligible & ~w_taken[b];
    assign w_start     = (|w_aged_left) ? '0 : r_rr_ptr;
    assign w_mask      = (|w_aged_left) ? w_aged_left : (w_eligible & ~w_taken[b]);
`else
    assign w_start = r_rr_ptr;
    assign w_mask  = w_eligible & ~w_taken[b];
`endif

    rr_select #(
      .N (NUM_REQ),
      .W (PTR_W)
    ) u_rr_select (
      .i_start (w_start),
      .i_mask  (w_mask),
      .o_valid (w_valid[b]),
      .o_index (w_index[b])
    );

    assign w_taken[b+1] = w_taken[b] |
                          (w_valid[b] ? (NUM_REQ'(1) << w_index[b]) : '0);
    assign w_gbus[b+1]  = w_gbus[b] |
                          (w_valid[b] ? (GBUS_W'(b) << (w_index[b] * BUS_W)) : '0);
    assign w_ptr[b+1]   = !w_valid[b] ? w_ptr[b] :
                          (w_index[b] == PTR_W'(NUM_REQ - 1)) ? '0 :
                          w_index[b] + 1'b1;
  end

`ifdef CDB_ARBITER_AGING_EN
  for (genvar p = 0; p < NUM_REQ; p++) begin : g_age
    logic [AGE_W-1:0] r_age;
    assign w_aged[p] = (r_age == AGE_W'(AGE_LIMIT));
    always_ff @(posedge i_clock) begin
      if (i_reset || i_flush) begin
        r_age <= '0;
      end else if (w_taken[NUM_BUS][p]) begin
        r_age <= '0;
      end else if (w_eligible[p] && !w_aged[p]) begin
        r_age <= r_age + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_grant     <= '0;
      r_bus_busy  <= '0;
      r_grant_bus <= '0;
      r_rr_ptr    <= '0;
    end else if (i_flush) begin
      r_grant     <= '0;
      r_bus_busy  <= '0;
      r_grant_bus <= '0;
    end else begin
      r_grant     <= w_taken[NUM_BUS];
      // Slots fill in ascending order, so a slot is busy iff its search hit.
      r_bus_busy  <= w_valid;
      r_grant_bus <= w_gbus[NUM_BUS];
      r_rr_ptr    <= w_ptr[NUM_BUS];
    end
  end

  assign o_grant     = r_grant;
  assign o_bus_busy  = r_bus_busy;
  assign o_grant_bus = r_grant_bus;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of result producers (ALU, branch, load/store, mul/div).
REQ-002 SHALL have parameter NUM_BUS, default 2: number of common data bus slots per cycle.
REQ-003 SHALL have parameter AGE_LIMIT, default 8: cycles of waiting after which a requester is aged.
REQ-004 SHALL have port i_clock  input  1  clock; single clock domain, all state on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port i_flush  input  1  pipeline flush from common signal bus.
REQ-007 SHALL have port i_request  input  NUM_REQ  per-producer result-ready level, held until granted.
REQ-008 SHALL have port o_grant  output  NUM_REQ  registered per-producer grant, one-cycle pulse.
REQ-009 SHALL have port o_grant_bus  output  NUM_REQ*$clog2(NUM_BUS)  bus index for each granted producer.
REQ-010 SHALL have port o_bus_busy  output  NUM_BUS  registered; bus slot carries a granted result this cycle.

Function
REQ-011 SHALL sample i_request at edge t; grants appear on o_grant at t+1 (latency 1 cycle).
REQ-012 SHALL ignore i_request[i] in any cycle where o_grant[i] is high, preventing double grant while the producer drops its request.
REQ-013 SHALL grant at most NUM_BUS producers per cycle and at most one bus per producer.
REQ-014 SHALL assign buses in ascending order (first winner -> bus 0, second -> bus 1); o_bus_busy[b] high iff bus b assigned.
REQ-015 SHALL use rotating priority: register rr_ptr (reset 0) is the highest-priority index; search wraps from NUM_REQ-1 to 0.
REQ-016 SHALL, after any cycle with at least one grant, set rr_ptr to (index of last winner + 1) mod NUM_REQ; rr_ptr is unchanged when no grant is made.
REQ-017 SHALL drive o_grant_bus fields of ungranted producers to 0.
REQ-018 SHALL, with zero eligible requests, drive o_grant and o_bus_busy to 0.
REQ-019 SHALL, on i_flush, clear o_grant, o_bus_busy, o_grant_bus and age counters at the next edge, keep rr_ptr, and make no grant for requests sampled in the flush cycle.
REQ-020 SHALL give i_reset priority over i_flush when both are asserted.

Reset
REQ-021 SHALL on i_reset set o_grant=0, o_grant_bus=0, o_bus_busy=0, rr_ptr=0, all age counters=0; first grant possible at the second edge after reset deasserts.

Configuration
REQ-022 SHALL compile aging when macro CDB_ARBITER_AGING_EN is defined: per-producer counter increments each cycle eligible-but-not-granted, saturates at AGE_LIMIT, and clears on grant.
REQ-023 SHALL, with CDB_ARBITER_AGING_EN defined, grant aged producers first (ascending index), then fill remaining buses by rotating priority.
REQ-024 SHALL, without CDB_ARBITER_AGING_EN, contain no age counters and arbitrate by pure rotating priority.

Structure
REQ-025 SHALL place the producer index enum (ALU=0, BRANCH=1, LOAD_STORE=2, MUL_DIV=3) and CDB_COUNT=2 in pkg_defines.
REQ-026 SHALL implement the wrap-around priority search as sub-module rr_select, which returns the first eligible index at or after a start pointer under a mask; cdb_arbiter instantiates it once per bus slot, each instance masking earlier winners.

Verification
REQ-027 SHALL cover: reset; i_request=4'b1111 held, rr_ptr=0 -> t+1 o_grant=4'b0011, buses 0/1; next cycle requests 0,1 masked -> o_grant=4'b1100, rr_ptr wraps to 0.
REQ-028 SHALL cover: rr_ptr=3, i_request=4'b1001 -> o_grant=4'b1001, producer 3 on bus 0, producer 0 on bus 1, rr_ptr becomes 1.
REQ-029 SHALL cover: single request 4'b0100 -> o_grant=4'b0100, o_bus_busy=2'b01, grant pulse exactly one cycle.
REQ-030 SHALL cover: i_flush asserted with i_request=4'b1111 -> next cycle o_grant=0, o_bus_busy=0, rr_ptr unchanged.
REQ-031 SHALL cover with CDB_ARBITER_AGING_EN and AGE_LIMIT=2: producer 3 starved for 2 cycles -> granted on bus 0 in the following cycle regardless of rr_ptr.
REQ-032 SHALL cover: i_reset asserted mid-stream with i_request=4'b1111 -> outputs 0 at next edge, first post-reset grant goes to producers 0 and 1.
